// File: rtl/pfb_unswitch.sv
// Synthesis-side frame reorder for the 2x-oversampled PFB: ping-pong frame buffer
// that replays the previous frame in lockstep with the incoming one, rotated by N/2 on odd frames.
module pfb_unswitch #(
    parameter int B = 32,
    parameter int L = 4,
    parameter int N = 64
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    input  logic [2*L*B-1:0]   s_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    output logic [2*L*B-1:0]   m_axis_tdata,
    output logic               sync_err
);

    localparam int W    = 2 * L * B;
    localparam int D    = N / (2 * L);
    localparam int AW   = (D > 1) ? $clog2(D) : 1;
    localparam int HALF = D / 2;

    localparam logic [AW-1:0] LAST_IDX = AW'(D - 1);
    localparam logic [AW:0]   D_W      = (AW + 1)'(D);
    localparam logic [AW:0]   HALF_W   = (AW + 1)'(HALF);

    logic [W-1:0]  r_bank0 [D];
    logic [W-1:0]  r_bank1 [D];

    logic [AW-1:0] r_wcnt;
    logic          r_wb;
    logic          r_primed;
    logic          r_par;
    logic          r_rpar;

    logic          r_m_tvalid;
    logic          r_m_tlast;
    logic [W-1:0]  r_m_tdata;
    logic          r_sync_err;

    logic          w_at_end;
    logic          w_good;
    logic          w_mis;
    logic [AW:0]   w_sum;
    logic [AW:0]   w_rot;
    logic [AW-1:0] w_rd_addr;
    logic [W-1:0]  w_rd_word;

    assign w_at_end = (r_wcnt == LAST_IDX);
    assign w_good   = s_axis_tvalid & s_axis_tlast & w_at_end;
    assign w_mis    = s_axis_tvalid & (s_axis_tlast ^ w_at_end);

    // A half-frame rotation is exactly D/2 whole beats, so only the address rotates.
    assign w_sum     = {1'b0, r_wcnt} + HALF_W;
    assign w_rot     = (w_sum >= D_W) ? (w_sum - D_W) : w_sum;
    assign w_rd_addr = r_rpar ? w_rot[AW-1:0] : r_wcnt;
    assign w_rd_word = r_wb ? r_bank0[w_rd_addr] : r_bank1[w_rd_addr];

    always_ff @(posedge aclk) begin
        if (s_axis_tvalid) begin
            if (r_wb) begin
                r_bank1[r_wcnt] <= s_axis_tdata;
            end else begin
                r_bank0[r_wcnt] <= s_axis_tdata;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wcnt   <= '0;
            r_wb     <= 1'b0;
            r_primed <= 1'b0;
            r_par    <= 1'b0;
            r_rpar   <= 1'b0;
        end else if (w_good) begin
            r_wcnt   <= '0;
            r_wb     <= ~r_wb;
            r_primed <= 1'b1;
            r_rpar   <= r_par;
            r_par    <= ~r_par;
        end else if (w_mis) begin
            // Resync: drop the partial frame; the next frame restarts at parity 0.
            r_wcnt   <= '0;
            r_primed <= 1'b0;
            r_par    <= 1'b0;
        end else if (s_axis_tvalid) begin
            r_wcnt   <= r_wcnt + AW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_m_tvalid <= s_axis_tvalid & r_primed;
            r_sync_err <= w_mis;
            if (s_axis_tvalid && r_primed) begin
                r_m_tdata <= w_rd_word;
                r_m_tlast <= w_at_end;
            end else begin
                r_m_tlast <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdata  = r_m_tdata;
    assign sync_err      = r_sync_err;

endmodule

// File: tb/tb_pfb_unswitch.sv
// Scoreboard bench for pfb_unswitch: directed frames with hand-written expected beats,
// checked by an independent monitor on the falling clock edge.
module tb_pfb_unswitch;

    localparam int W = 256;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tlast = 1'b0;
    logic [W-1:0]   s_axis_tdata = '0;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic [W-1:0]   m_axis_tdata;
    logic           sync_err;

    int n_vec = 0;
    int n_err = 0;

    // Expected beats: {tlast, tdata}
    logic [W:0] exp_q[$];

    // Per-beat expectations issued by the driver, registered like the DUT output.
    logic tb_vld_now = 1'b0;
    logic tb_err_now = 1'b0;
    logic exp_vld_d;
    logic exp_err_d;

    int E_F0[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int E_F1R[8] = '{20, 21, 22, 23, 16, 17, 18, 19};
    int E_F2[8]  = '{32, 33, 34, 35, 36, 37, 38, 39};
    int E_F3[8]  = '{48, 49, 50, 51, 52, 53, 54, 55};
    int E_F3R[8] = '{52, 53, 54, 55, 48, 49, 50, 51};
    int E_NONE[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int GAP_TAB[8] = '{2, 2, 0, 1, 2, 0, 3, 2};

    pfb_unswitch #(.B(32), .L(4), .N(64)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .sync_err      (sync_err)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            exp_vld_d <= 1'b0;
            exp_err_d <= 1'b0;
        end else begin
            exp_vld_d <= s_axis_tvalid & tb_vld_now;
            exp_err_d <= s_axis_tvalid & tb_err_now;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge aclk) begin
        logic [W:0] exp_w;
        n_vec++;
        if (m_axis_tvalid !== exp_vld_d) begin
            n_err++;
            $display("FAIL tvalid: got %b expected %b at %0t", m_axis_tvalid, exp_vld_d, $time);
        end
        n_vec++;
        if (sync_err !== exp_err_d) begin
            n_err++;
            $display("FAIL sync_err: got %b expected %b at %0t", sync_err, exp_err_d, $time);
        end
        if (m_axis_tvalid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got data %h with no expected beat at %0t",
                         m_axis_tdata[31:0], $time);
            end else begin
                exp_w = exp_q.pop_front();
                if (m_axis_tdata !== exp_w[W-1:0] || m_axis_tlast !== exp_w[W]) begin
                    n_err++;
                    $display("FAIL beat: got last=%b data=%h expected last=%b data=%h at %0t",
                             m_axis_tlast, m_axis_tdata, exp_w[W], exp_w[W-1:0], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] lanes(input int v);
        logic [31:0] s;
        s = 32'(v);
        return {8{s}};
    endfunction

    task automatic drive_beat(input int v, input logic last, input logic ev,
                              input int ex, input logic elast, input logic eerr);
        @(negedge aclk);
        #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = lanes(v);
        s_axis_tlast  = last;
        tb_vld_now    = ev;
        tb_err_now    = eerr;
        if (ev) exp_q.push_back({elast, lanes(ex)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            tb_vld_now    = 1'b0;
            tb_err_now    = 1'b0;
        end
    endtask

    // Frame f, nb beats, tlast at beat tl_at (-1 = never); emit selects expected output.
    task automatic send_frame(input int f, input int nb, input int tl_at, input logic emit,
                              input int e[8], input logic gaps);
        logic last;
        logic err;
        for (int j = 0; j < nb; j++) begin
            last = (j == tl_at);
            err  = (last && j != 7) || (!last && j == 7);
            drive_beat(16 * f + j, last, emit, e[j], (j == 7), err);
            if (gaps) idle(GAP_TAB[j]);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || sync_err !== 1'b0 ||
            m_axis_tdata !== '0) begin
            n_err++;
            $display("FAIL %s: got vld=%b last=%b err=%b data=%h expected all zero",
                     name, m_axis_tvalid, m_axis_tlast, sync_err, m_axis_tdata);
        end
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected beats never appeared, expected 0 left",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #1;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tb_vld_now    = 1'b0;
        tb_err_now    = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held with random input, then released with no input.
        aresetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            #1;
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tlast  = 1'($urandom_range(0, 1));
            s_axis_tdata  = lanes(int'($urandom_range(0, 255)));
            #1;
            check_zero("reset_hold");
        end
        @(negedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        aresetn       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            #2;
            check_zero("reset_release_idle");
        end

        // Continuous stream: F0 silent, F1 pass-through, F2 rotated, F3 pass-through.
        send_frame(0, 8, 7, 1'b0, E_NONE, 1'b0);
        send_frame(1, 8, 7, 1'b1, E_F0, 1'b0);
        send_frame(2, 8, 7, 1'b1, E_F1R, 1'b0);
        send_frame(3, 8, 7, 1'b1, E_F2, 1'b0);
        idle(3);
        check_drained("continuous");

        // Same stream with input gaps.
        do_reset();
        send_frame(0, 8, 7, 1'b0, E_NONE, 1'b1);
        send_frame(1, 8, 7, 1'b1, E_F0, 1'b1);
        send_frame(2, 8, 7, 1'b1, E_F1R, 1'b1);
        idle(3);
        check_drained("gaps");

        // Early tlast on beat 5 of F1.
        do_reset();
        send_frame(0, 8, 7, 1'b0, E_NONE, 1'b0);
        send_frame(1, 6, 5, 1'b1, E_F0, 1'b0);
        send_frame(2, 8, 7, 1'b0, E_NONE, 1'b0);
        send_frame(3, 8, 7, 1'b1, E_F2, 1'b0);
        send_frame(4, 8, 7, 1'b1, E_F3R, 1'b0);
        idle(3);
        check_drained("early_tlast");

        // Missing tlast on beat 7 of F2.
        do_reset();
        send_frame(0, 8, 7, 1'b0, E_NONE, 1'b0);
        send_frame(1, 8, 7, 1'b1, E_F0, 1'b0);
        send_frame(2, 8, -1, 1'b1, E_F1R, 1'b0);
        send_frame(3, 8, 7, 1'b0, E_NONE, 1'b0);
        send_frame(4, 8, 7, 1'b1, E_F3, 1'b0);
        idle(3);
        check_drained("missing_tlast");

        // Reset pulsed during beat 3 of F1, then a full restart.
        do_reset();
        send_frame(0, 8, 7, 1'b0, E_NONE, 1'b0);
        for (int j = 0; j < 3; j++) drive_beat(16 + j, 1'b0, 1'b1, j, 1'b0, 1'b0);
        @(negedge aclk);
        #1;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = lanes(19);
        tb_vld_now    = 1'b0;
        tb_err_now    = 1'b0;
        #1;
        check_zero("midframe_reset");
        check_drained("midframe_reset_queue");
        repeat (2) @(negedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b1;
        send_frame(0, 8, 7, 1'b0, E_NONE, 1'b0);
        send_frame(1, 8, 7, 1'b1, E_F0, 1'b0);
        send_frame(2, 8, 7, 1'b1, E_F1R, 1'b0);
        idle(3);
        check_drained("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
